// File: rtl/armleocpu_clint_gen2_if.sv
// AXI4-Lite bus bundle for the core-local interruptor.
// The master drives addresses, data and the READY of the return channels;
// the slave returns the address/data READYs, responses and read data.
interface armleocpu_clint_gen2_if;
  logic [15:0] AXI_AWADDR;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;

  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;

  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;

  logic [15:0] AXI_ARADDR;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;

  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    output AXI_BREADY, AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
    input  AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    input  AXI_BREADY, AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
    output AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );
endinterface

// File: rtl/armleocpu_clint_gen2.sv
// Core-local interruptor: per-hart msip bits, per-hart 64-bit mtimecmp,
// a shared prescaled 64-bit mtime, all behind one AXI4-Lite slave that
// serves a single transaction at a time.
module armleocpu_clint_gen2 #(
  parameter int HART_COUNT       = 8,
  parameter int HART_COUNT_WIDTH = 5,
  parameter int MTIME_PRESCALE   = 1,
  parameter bit EXT_TICK_EN      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mtime_tick,
  armleocpu_clint_gen2_if.slave bus,
  output logic [HART_COUNT-1:0] hart_swi,
  output logic [HART_COUNT-1:0] hart_timeri
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;
  typedef enum logic [2:0] {
    R_NONE, R_MSIP, R_CMP_LO, R_CMP_HI, R_MTIME_LO, R_MTIME_HI
  } reg_kind_t;

  typedef struct packed {
    reg_kind_t                   kind;
    logic [HART_COUNT_WIDTH-1:0] hart;
    logic [1:0]                  resp;
  } decode_t;

  // Maps a bus address onto a register kind, hart index and response code.
  function automatic decode_t decode(input logic [15:0] addr);
    decode_t d;
    d.kind = R_NONE;
    d.hart = '0;
    d.resp = RESP_DECERR;
    if (addr[15:14] == 2'b00) begin
      if (int'(addr[13:2]) < HART_COUNT) begin
        d.kind = R_MSIP;
        d.hart = addr[2 +: HART_COUNT_WIDTH];
      end
    end else if (addr[15:14] == 2'b01) begin
      if (int'(addr[13:3]) < HART_COUNT) begin
        d.kind = addr[2] ? R_CMP_HI : R_CMP_LO;
        d.hart = addr[3 +: HART_COUNT_WIDTH];
      end
    end else if (addr[15:3] == 13'h17FF) begin
      d.kind = addr[2] ? R_MTIME_HI : R_MTIME_LO;
    end
    if (d.kind != R_NONE) d.resp = (addr[1:0] != 2'b00) ? RESP_SLVERR : RESP_OKAY;
    return d;
  endfunction

  // Replaces only the strobed bytes of a 32-bit word.
  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    return r;
  endfunction

  state_t          state;
  decode_t         wr_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic [HART_COUNT-1:0] msip;
  logic [63:0]     mtimecmp [HART_COUNT];
  logic [63:0]     mtime;
  logic [15:0]     prescale_cnt;

  decode_t         aw_dec;
  decode_t         ar_dec;
  logic [31:0]     rd_value;
  logic            wr_commit;
  logic            tick_qual;

  assign aw_dec    = decode(bus.AXI_AWADDR);
  assign ar_dec    = decode(bus.AXI_ARADDR);
  assign wr_commit = (state == S_WDATA) && bus.AXI_WVALID && (wr_q.resp == RESP_OKAY);
  assign tick_qual = EXT_TICK_EN ? mtime_tick : 1'b1;

  assign bus.AXI_AWREADY = (state == S_IDLE) && bus.AXI_AWVALID;
  assign bus.AXI_ARREADY = (state == S_IDLE) && !bus.AXI_AWVALID && bus.AXI_ARVALID;
  assign bus.AXI_WREADY  = (state == S_WDATA);
  assign bus.AXI_BVALID  = (state == S_WRESP);
  assign bus.AXI_BRESP   = wr_q.resp;
  assign bus.AXI_RVALID  = (state == S_RDATA);
  assign bus.AXI_RDATA   = rdata_q;
  assign bus.AXI_RRESP   = rresp_q;
  assign hart_swi        = msip;

  // Selects the read value for the address presented on AR this cycle.
  always_comb begin
    // NOTE: default first so every path assigns rd_value and no latch is inferred.
    rd_value = '0;
    for (int h = 0; h < HART_COUNT; h++) begin
      if (ar_dec.hart == HART_COUNT_WIDTH'(h)) begin
        case (ar_dec.kind)
          R_MSIP:   rd_value = {31'b0, msip[h]};
          R_CMP_LO: rd_value = mtimecmp[h][31:0];
          R_CMP_HI: rd_value = mtimecmp[h][63:32];
          default:  ;
        endcase
      end
    end
    if (ar_dec.kind == R_MTIME_LO) rd_value = mtime[31:0];
    if (ar_dec.kind == R_MTIME_HI) rd_value = mtime[63:32];
    if (ar_dec.resp != RESP_OKAY)  rd_value = '0;
  end

  // Bus FSM: accepts one write or read at a time, writes winning ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_q    <= '{kind: R_NONE, hart: '0, resp: RESP_OKAY};
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (bus.AXI_AWVALID) begin
            wr_q  <= aw_dec;
            state <= S_WDATA;
          end else if (bus.AXI_ARVALID) begin
            rdata_q <= rd_value;
            rresp_q <= ar_dec.resp;
            state   <= S_RDATA;
          end
        end
        S_WDATA: if (bus.AXI_WVALID) state <= S_WRESP;
        S_WRESP: if (bus.AXI_BREADY) state <= S_IDLE;
        S_RDATA: if (bus.AXI_RREADY) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-hart msip and mtimecmp updates from committed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip <= '0;
      // NOTE: the compare array is reset on purpose: all-ones keeps timers quiet until software arms them.
      for (int h = 0; h < HART_COUNT; h++) mtimecmp[h] <= '1;
    end else if (wr_commit) begin
      for (int h = 0; h < HART_COUNT; h++) begin
        if (wr_q.hart == HART_COUNT_WIDTH'(h)) begin
          case (wr_q.kind)
            R_MSIP:   if (bus.AXI_WSTRB[0]) msip[h] <= bus.AXI_WDATA[0];
            R_CMP_LO: mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0],  bus.AXI_WDATA, bus.AXI_WSTRB);
            R_CMP_HI: mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], bus.AXI_WDATA, bus.AXI_WSTRB);
            default:  ;
          endcase
        end
      end
    end
  end

  // Time base: prescaled increment, overridden (and prescaler cleared) by writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime        <= '0;
      prescale_cnt <= '0;
    end else if (wr_commit && wr_q.kind == R_MTIME_LO) begin
      mtime[31:0]  <= merge(mtime[31:0], bus.AXI_WDATA, bus.AXI_WSTRB);
      prescale_cnt <= '0;
    end else if (wr_commit && wr_q.kind == R_MTIME_HI) begin
      mtime[63:32] <= merge(mtime[63:32], bus.AXI_WDATA, bus.AXI_WSTRB);
      prescale_cnt <= '0;
    end else if (tick_qual) begin
      if (prescale_cnt == 16'(MTIME_PRESCALE - 1)) begin
        prescale_cnt <= '0;
        mtime        <= mtime + 64'd1;
      end else begin
        prescale_cnt <= prescale_cnt + 16'd1;
      end
    end
  end

  // Registered timer interrupts from the current compare and time values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hart_timeri <= '0;
    end else begin
      for (int h = 0; h < HART_COUNT; h++) hart_timeri[h] <= (mtimecmp[h] <= mtime);
    end
  end

endmodule

// File: tb/tb_armleocpu_clint_gen2.sv
// Directed bench: dut0 runs on every clock (P=1), dut1 on an external tick
// with P=4. A select bit steers the shared bus stimulus to one of them.
module tb_armleocpu_clint_gen2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mtime_tick = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        sel = 1'b0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  armleocpu_clint_gen2_if bus0();
  armleocpu_clint_gen2_if bus1();

  assign bus0.AXI_AWADDR  = awaddr;            assign bus1.AXI_AWADDR  = awaddr;
  assign bus0.AXI_WDATA   = wdata;             assign bus1.AXI_WDATA   = wdata;
  assign bus0.AXI_WSTRB   = wstrb;             assign bus1.AXI_WSTRB   = wstrb;
  assign bus0.AXI_ARADDR  = araddr;            assign bus1.AXI_ARADDR  = araddr;
  assign bus0.AXI_AWVALID = awvalid & ~sel;    assign bus1.AXI_AWVALID = awvalid & sel;
  assign bus0.AXI_WVALID  = wvalid & ~sel;     assign bus1.AXI_WVALID  = wvalid & sel;
  assign bus0.AXI_BREADY  = bready & ~sel;     assign bus1.AXI_BREADY  = bready & sel;
  assign bus0.AXI_ARVALID = arvalid & ~sel;    assign bus1.AXI_ARVALID = arvalid & sel;
  assign bus0.AXI_RREADY  = rready & ~sel;     assign bus1.AXI_RREADY  = rready & sel;

  logic [7:0] swi0, tmr0, swi1, tmr1;

  armleocpu_clint_gen2 #(.HART_COUNT(8), .HART_COUNT_WIDTH(5), .MTIME_PRESCALE(1), .EXT_TICK_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mtime_tick(mtime_tick), .bus(bus0), .hart_swi(swi0), .hart_timeri(tmr0)
  );
  armleocpu_clint_gen2 #(.HART_COUNT(8), .HART_COUNT_WIDTH(5), .MTIME_PRESCALE(4), .EXT_TICK_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mtime_tick(mtime_tick), .bus(bus1), .hart_swi(swi1), .hart_timeri(tmr1)
  );

  logic        awready, arready, wready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  assign awready = sel ? bus1.AXI_AWREADY : bus0.AXI_AWREADY;
  assign arready = sel ? bus1.AXI_ARREADY : bus0.AXI_ARREADY;
  assign wready  = sel ? bus1.AXI_WREADY  : bus0.AXI_WREADY;
  assign bvalid  = sel ? bus1.AXI_BVALID  : bus0.AXI_BVALID;
  assign rvalid  = sel ? bus1.AXI_RVALID  : bus0.AXI_RVALID;
  assign bresp   = sel ? bus1.AXI_BRESP   : bus0.AXI_BRESP;
  assign rresp   = sel ? bus1.AXI_RRESP   : bus0.AXI_RRESP;
  assign rdata   = sel ? bus1.AXI_RDATA   : bus0.AXI_RDATA;

  logic [7:0] swi_at_w, swi_at_b, tmr_at_b;

  // Full write: AW, then W, then B with BREADY already high.
  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int w_cyc);
    int n;
    @(posedge clk); #1;
    awaddr = addr; awvalid = 1; wdata = data; wstrb = strb; wvalid = 0; bready = 1;
    n = 0; @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) begin checks++; failures++; $display("FAIL aw_timeout addr=%h: AWREADY=0, required 1", addr); end
    @(posedge clk); #1; awvalid = 0; wvalid = 1;
    n = 0; @(negedge clk);
    while (!wready && n < 20) begin @(negedge clk); n++; end
    if (!wready) begin checks++; failures++; $display("FAIL w_timeout addr=%h: WREADY=0, required 1", addr); end
    w_cyc = cyc; swi_at_w = sel ? swi1 : swi0;
    @(posedge clk); #1; wvalid = 0;
    n = 0; @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin checks++; failures++; $display("FAIL b_timeout addr=%h: BVALID=0, required 1", addr); end
    resp = bresp; swi_at_b = sel ? swi1 : swi0; tmr_at_b = sel ? tmr1 : tmr0;
    @(posedge clk); #1; bready = 0;
  endtask

  // Full read: AR, then R with RREADY already high.
  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int ar_cyc);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1; rready = 1;
    n = 0; @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin checks++; failures++; $display("FAIL ar_timeout addr=%h: ARREADY=0, required 1", addr); end
    ar_cyc = cyc;
    @(posedge clk); #1; arvalid = 0;
    n = 0; @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin checks++; failures++; $display("FAIL r_timeout addr=%h: RVALID=0, required 1", addr); end
    data = rdata; resp = rresp;
    @(posedge clk); #1; rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int c; int n;
    sel = 0;
    @(negedge clk);
    checks++; if ({swi0, tmr0, swi1, tmr1} !== 32'h0) begin failures++; $display("FAIL reset_irq: got %h required 0", {swi0, tmr0, swi1, tmr1}); end
    checks++; if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin failures++; $display("FAIL reset_handshake: got %b required 00000", {awready, arready, wready, bvalid, rvalid}); end
    @(posedge clk); #1; araddr = 16'hBFF8; arvalid = 1; rready = 0;
    n = 0; @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; arvalid = 0;
    @(negedge clk);
    checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL reset_pre_rvalid: got %b required 1", rvalid); end
    #2 rst_n = 0; #1;
    checks++; if ({rvalid, rdata, rresp} !== 35'b0) begin failures++; $display("FAIL reset_async: rvalid/rdata/rresp got %h required 0", {rvalid, rdata, rresp}); end
    @(posedge clk); @(posedge clk); #1; rst_n = 1;
    axi_read(16'h4000, d, r, c);
    checks++; if (d !== 32'hFFFF_FFFF || r !== 2'b00) begin failures++; $display("FAIL reset_cmp_read: got %h/%b required ffffffff/00", d, r); end
    checks++; if (tmr0 !== 8'h00) begin failures++; $display("FAIL reset_timeri: got %h required 00", tmr0); end
  endtask

  task automatic test_swi();
    logic [31:0] d; logic [1:0] r; int c;
    sel = 0;
    axi_write(16'h000C, 32'h1, 4'hF, r, c);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL swi_bresp: got %b required 00", r); end
    checks++; if (swi_at_w !== 8'h00) begin failures++; $display("FAIL swi_at_w: got %h required 00", swi_at_w); end
    checks++; if (swi_at_b !== 8'h08) begin failures++; $display("FAIL swi_after_w: got %h required 08", swi_at_b); end
    axi_read(16'h000C, d, r, c);
    checks++; if (d !== 32'h1 || r !== 2'b00) begin failures++; $display("FAIL swi_read: got %h/%b required 00000001/00", d, r); end
    axi_write(16'h0020, 32'h1, 4'hF, r, c);
    checks++; if (r !== 2'b11) begin failures++; $display("FAIL swi_decerr_w: got %b required 11", r); end
    checks++; if (swi0 !== 8'h08) begin failures++; $display("FAIL swi_unchanged: got %h required 08", swi0); end
    axi_read(16'h0020, d, r, c);
    checks++; if (d !== 32'h0 || r !== 2'b11) begin failures++; $display("FAIL swi_decerr_r: got %h/%b required 00000000/11", d, r); end
  endtask

  task automatic test_timer();
    logic [1:0] r; int wm, c;
    sel = 0;
    axi_write(16'hBFF8, 32'h0, 4'hF, r, wm);
    axi_write(16'h4010, 32'h40, 4'hF, r, c);
    axi_write(16'h4014, 32'h0, 4'hF, r, c);
    @(negedge clk);
    while (cyc < wm + 'h41) @(negedge clk);
    checks++; if (tmr0 !== 8'h00) begin failures++; $display("FAIL timer_before: got %h required 00", tmr0); end
    @(negedge clk);
    checks++; if (tmr0 !== 8'h04) begin failures++; $display("FAIL timer_rise: got %h required 04", tmr0); end
    axi_write(16'h4014, 32'hFFFF_FFFF, 4'hF, r, c);
    checks++; if (tmr_at_b !== 8'h04) begin failures++; $display("FAIL timer_hold: got %h required 04", tmr_at_b); end
    @(negedge clk);
    checks++; if (tmr0 !== 8'h00) begin failures++; $display("FAIL timer_drop: got %h required 00", tmr0); end
  endtask

  task automatic test_prescaler();
    int gaps[12] = '{1, 3, 1, 2, 5, 1, 1, 4, 2, 1, 3, 1};
    logic [31:0] d; logic [1:0] r; int c;
    sel = 1;
    axi_read(16'hBFF8, d, r, c);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL presc_start: got %h required 0", d); end
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      #1 mtime_tick = 1; @(posedge clk); #1 mtime_tick = 0;
      repeat (gaps[i]) @(posedge clk);
    end
    axi_read(16'hBFF8, d, r, c);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL presc_12_ticks: got %h required 3", d); end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 mtime_tick = 1; @(posedge clk); #1 mtime_tick = 0; repeat (2) @(posedge clk);
    end
    axi_read(16'hBFF8, d, r, c);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL presc_15_ticks: got %h required 3", d); end
    @(posedge clk);
    #1 mtime_tick = 1; @(posedge clk); #1 mtime_tick = 0;
    axi_read(16'hBFF8, d, r, c);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL presc_16_ticks: got %h required 4", d); end
  endtask

  task automatic test_mtime_wrap();
    logic [31:0] d; logic [1:0] r; int wa, wb, c1, c2;
    logic [63:0] expv;
    sel = 0;
    axi_write(16'hBFFC, 32'hFFFF_FFFF, 4'hF, r, wa);
    axi_write(16'hBFF8, 32'hFFFF_FFFE, 4'hF, r, wb);
    axi_read(16'hBFF8, d, r, c1);
    expv = 64'hFFFF_FFFF_FFFF_FFFE + 64'(c1 - wb - 1);
    checks++; if (d !== expv[31:0]) begin failures++; $display("FAIL wrap_lo: got %h required %h", d, expv[31:0]); end
    axi_read(16'hBFFC, d, r, c2);
    expv = 64'hFFFF_FFFF_FFFF_FFFE + 64'(c2 - wb - 1);
    checks++; if (d !== expv[63:32]) begin failures++; $display("FAIL wrap_hi: got %h required %h", d, expv[63:32]); end
    sel = 1;
    axi_write(16'hBFF8, 32'h1234_5678, 4'hF, r, c1);
    axi_write(16'hBFF8, 32'hDEAD_BEAA, 4'h1, r, c1);
    axi_read(16'hBFF8, d, r, c1);
    checks++; if (d !== 32'h1234_56AA) begin failures++; $display("FAIL strb_byte0: got %h required 123456aa", d); end
    axi_write(16'hBFFC, 32'hABCD_0000, 4'hC, r, c1);
    axi_read(16'hBFFC, d, r, c1);
    checks++; if (d !== 32'hABCD_0000) begin failures++; $display("FAIL strb_hi: got %h required abcd0000", d); end
    axi_read(16'hBFF8, d, r, c1);
    checks++; if (d !== 32'h1234_56AA) begin failures++; $display("FAIL strb_lo_kept: got %h required 123456aa", d); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d; logic [1:0] r; int c;
    sel = 0;
    axi_write(16'h4002, 32'h0, 4'hF, r, c);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL misalign_w: got %b required 10", r); end
    axi_read(16'h4000, d, r, c);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL misalign_nochange: got %h required ffffffff", d); end
    axi_read(16'hBFF9, d, r, c);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL misalign_r: got %h/%b required 00000000/10", d, r); end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    @(posedge clk); #1;
    awaddr = 16'h0004; wdata = 32'h1; wstrb = 4'hF; awvalid = 1;
    araddr = 16'h0004; arvalid = 1; bready = 0; rready = 0;
    @(negedge clk);
    checks++; if ({awready, arready} !== 2'b10) begin failures++; $display("FAIL arb_idle: aw/ar ready got %b required 10", {awready, arready}); end
    @(posedge clk); #1; awvalid = 0; wvalid = 1;
    @(negedge clk);
    checks++; if ({wready, arready} !== 2'b10) begin failures++; $display("FAIL arb_wdata: w/ar ready got %b required 10", {wready, arready}); end
    @(posedge clk); #1; wvalid = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({bvalid, arready, bresp} !== 4'b1000) begin failures++; $display("FAIL arb_wresp: bvalid/arready/bresp got %b required 1000", {bvalid, arready, bresp}); end
    @(posedge clk); #1; bready = 1;
    @(negedge clk);
    @(posedge clk); #1; bready = 0;
    @(negedge clk);
    checks++; if ({bvalid, arready} !== 2'b01) begin failures++; $display("FAIL arb_ar_after_b: bvalid/arready got %b required 01", {bvalid, arready}); end
    @(posedge clk); #1; arvalid = 0; rready = 1;
    @(negedge clk);
    checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h1}) begin failures++; $display("FAIL arb_read: rvalid/rresp/rdata got %b/%b/%h required 1/00/00000001", rvalid, rresp, rdata); end
    checks++; if (swi0 !== 8'h0A) begin failures++; $display("FAIL arb_swi: got %h required 0a", swi0); end
    @(posedge clk); #1; rready = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_swi();
    test_timer();
    test_prescaler();
    test_mtime_wrap();
    test_misaligned();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
